// File: rtl/vec_act_stream_pkg.sv
// Shared types for the vector activation stream: element width, activation modes, FSM states.
package vec_act_stream_pkg;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_RSVD  = 2'd3
  } act_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } act_state_e;

  function automatic int elem_width(input int exp_w, input int frac_w);
    return 1 + exp_w + frac_w;
  endfunction

endpackage

// File: rtl/vec_act_stream_float_act_lane.sv
// Combinational single-element activation: pass, ReLU, or leaky ReLU with a power-of-two slope.
module float_act_lane
  import vec_act_stream_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int LEAK_SHIFT = 3,
  localparam int FW = elem_width(EXP_WIDTH, FRAC_WIDTH)
) (
  input  logic [FW-1:0] elem_in,
  input  act_mode_e     mode,
  output logic [FW-1:0] elem_out
);

  localparam logic [EXP_WIDTH-1:0] SHIFT_E = EXP_WIDTH'(LEAK_SHIFT);

  logic                  sign_s;
  logic [EXP_WIDTH-1:0]  exp_s;
  logic [FRAC_WIDTH-1:0] frac_s;
  logic                  is_nan_s;
  logic                  is_inf_s;

  // Field decode and per-mode transform.
  always_comb begin
    sign_s   = elem_in[FW-1];
    exp_s    = elem_in[FW-2 -: EXP_WIDTH];
    frac_s   = elem_in[FRAC_WIDTH-1:0];
    is_nan_s = (&exp_s) & (|frac_s);
    is_inf_s = (&exp_s) & ~(|frac_s);
    elem_out = elem_in;
    case (mode)
      ACT_RELU: begin
        if (sign_s && !is_nan_s) begin
          elem_out = {FW{1'b0}};
        end else begin
          elem_out = elem_in;
        end
      end
      ACT_LEAKY: begin
        // The compare guards the subtraction, so the exponent never wraps.
        if (!sign_s || is_nan_s || is_inf_s) begin
          elem_out = elem_in;
        end else if (exp_s <= SHIFT_E) begin
          elem_out = {FW{1'b0}};
        end else begin
          elem_out = {sign_s, exp_s - SHIFT_E, frac_s};
        end
      end
      default: begin
        elem_out = elem_in;
      end
    endcase
  end

endmodule

// File: rtl/vec_act_stream.sv
// Handshaked vector activation unit, LANES elements transformed per cycle in place.
// Optional negative-element counter enabled by defining VEC_ACT_STATS_EN.
module vec_act_stream
  import vec_act_stream_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int VEC_SIZE   = 8,
  parameter int LANES      = 2,
  parameter int LEAK_SHIFT = 3,
  localparam int FW = elem_width(EXP_WIDTH, FRAC_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [VEC_SIZE*FW-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VEC_SIZE*FW-1:0] out_data
`ifdef VEC_ACT_STATS_EN
  ,
  output logic [$clog2(VEC_SIZE+1)-1:0] out_neg_count
`endif
);

  localparam int N     = VEC_SIZE / LANES;
  localparam int CHW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CHW-1:0] CHUNK_LAST = CHW'(N - 1);

  act_state_e             state_q, state_d;
  logic [CHW-1:0]         chunk_q, chunk_d;
  act_mode_e              mode_q, mode_d;
  logic [VEC_SIZE*FW-1:0] data_q, data_d;
  logic                   accept_s;

  logic [FW-1:0] lane_in  [LANES];
  logic [FW-1:0] lane_out [LANES];

  // Select the current chunk's elements from the result register.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = data_q[(int'(chunk_q) * LANES + l) * FW +: FW];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    float_act_lane #(
      .EXP_WIDTH (EXP_WIDTH),
      .FRAC_WIDTH(FRAC_WIDTH),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_lane (
      .elem_in (lane_in[g]),
      .mode    (mode_q),
      .elem_out(lane_out[g])
    );
  end

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept_s  = in_valid & in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;

  // Next-state, chunk sequencing and in-place write-back.
  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    mode_d  = mode_q;
    data_d  = data_q;
    if (accept_s) begin
      state_d = ST_BUSY;
      chunk_d = {CHW{1'b0}};
      mode_d  = act_mode_e'(in_mode);
      data_d  = in_data;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_BUSY: begin
          for (int l = 0; l < LANES; l++) begin
            data_d[(int'(chunk_q) * LANES + l) * FW +: FW] = lane_out[l];
          end
          if (chunk_q == CHUNK_LAST) begin
            state_d = ST_DONE;
            chunk_d = {CHW{1'b0}};
          end else begin
            chunk_d = chunk_q + CHW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      chunk_q <= {CHW{1'b0}};
      mode_q  <= ACT_PASS;
      data_q  <= {(VEC_SIZE*FW){1'b0}};
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

`ifdef VEC_ACT_STATS_EN
  localparam int CW = $clog2(VEC_SIZE + 1);

  logic [CW-1:0] neg_q, neg_d;
  logic [CW-1:0] lane_neg_s;

  // Negative, non-NaN elements of the untouched chunk, accumulated while busy.
  always_comb begin
    lane_neg_s = {CW{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      if (lane_in[l][FW-1] &&
          !((&lane_in[l][FW-2 -: EXP_WIDTH]) && (|lane_in[l][FRAC_WIDTH-1:0]))) begin
        lane_neg_s = lane_neg_s + CW'(1);
      end else begin
        lane_neg_s = lane_neg_s;
      end
    end
    neg_d = neg_q;
    if (accept_s) begin
      neg_d = {CW{1'b0}};
    end else if (state_q == ST_BUSY) begin
      neg_d = neg_q + lane_neg_s;
    end else begin
      neg_d = neg_q;
    end
  end

  // Negative-count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= {CW{1'b0}};
    end else begin
      neg_q <= neg_d;
    end
  end

  assign out_neg_count = neg_q;
`endif

endmodule

// File: tb/tb_vec_act_stream.sv
// Directed self-checking bench for vec_act_stream (VEC_SIZE=8, LANES=2, FP32, LEAK_SHIFT=3).
module tb_vec_act_stream;

  localparam int FW = 32;
  localparam int VW = 8 * FW;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [VW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
`ifdef VEC_ACT_STATS_EN
  logic [3:0]    out_neg_count;
`endif

  int checks = 0;
  int passes = 0;

  vec_act_stream #(
    .EXP_WIDTH (8),
    .FRAC_WIDTH(23),
    .VEC_SIZE  (8),
    .LANES     (2),
    .LEAK_SHIFT(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef VEC_ACT_STATS_EN
    ,
    .out_neg_count(out_neg_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element 0 sits in the low 32 bits.
  localparam logic [VW-1:0] VEC_A = {32'h3F000000, 32'hC0600000, 32'h7FC00000, 32'hFF800000,
                                     32'h7F800000, 32'h80000000, 32'h40000000, 32'hBF800000};
  localparam logic [VW-1:0] EXP_A_RELU = {32'h3F000000, 32'h00000000, 32'h7FC00000, 32'h00000000,
                                          32'h7F800000, 32'h00000000, 32'h40000000, 32'h00000000};
  localparam logic [VW-1:0] VEC_B = {32'hBFC00000, 32'hFFC00001, 32'h40000000, 32'hFF800000,
                                     32'h82000000, 32'h81800000, 32'h80000001, 32'hC1000000};
  localparam logic [VW-1:0] EXP_B_LEAKY = {32'hBE400000, 32'hFFC00001, 32'h40000000, 32'hFF800000,
                                           32'h80800000, 32'h00000000, 32'h00000000, 32'hBF800000};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    check("reset_in_ready", VW'(in_ready), VW'(1'b1));
    check("reset_out_valid", VW'(out_valid), VW'(1'b0));
    check("reset_out_data", out_data, '0);
`ifdef VEC_ACT_STATS_EN
    check("reset_neg", VW'(out_neg_count), VW'(4'd0));
`endif

    // ReLU vector; mode input flips to pass right after acceptance.
    in_valid = 1'b1;
    in_mode  = 2'd1;
    in_data  = VEC_A;
    step();
    in_valid = 1'b0;
    in_mode  = 2'd0;
    in_data  = '0;
    check("busy_in_ready", VW'(in_ready), VW'(1'b0));
    check("busy_out_valid_1", VW'(out_valid), VW'(1'b0));
    repeat (3) step();
    check("busy_out_valid_3", VW'(out_valid), VW'(1'b0));
    step();
    check("relu_valid", VW'(out_valid), VW'(1'b1));
    check("relu_data", out_data, EXP_A_RELU);
`ifdef VEC_ACT_STATS_EN
    check("relu_neg", VW'(out_neg_count), VW'(4'd4));
`endif

    // Backpressure: result held for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_data", out_data, EXP_A_RELU);
      check("bp_valid", VW'(out_valid), VW'(1'b1));
      check("bp_in_ready", VW'(in_ready), VW'(1'b0));
    end

    // Release with a new leaky vector accepted on the same edge.
    in_valid  = 1'b1;
    in_mode   = 2'd2;
    in_data   = VEC_B;
    out_ready = 1'b1;
    #1;
    check("release_in_ready", VW'(in_ready), VW'(1'b1));
    step();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    check("leaky_busy_valid", VW'(out_valid), VW'(1'b0));
    repeat (3) step();
    check("leaky_busy_valid_3", VW'(out_valid), VW'(1'b0));
    step();
    check("leaky_valid", VW'(out_valid), VW'(1'b1));
    check("leaky_data", out_data, EXP_B_LEAKY);
`ifdef VEC_ACT_STATS_EN
    check("leaky_neg", VW'(out_neg_count), VW'(4'd6));
`endif
    out_ready = 1'b1;
    step();
    check("drain_out_valid", VW'(out_valid), VW'(1'b0));
    check("drain_in_ready", VW'(in_ready), VW'(1'b1));
    out_ready = 1'b0;

    // Pass mode leaves every element untouched.
    in_valid = 1'b1;
    in_mode  = 2'd0;
    in_data  = VEC_A;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("pass_valid", VW'(out_valid), VW'(1'b1));
    check("pass_data", out_data, VEC_A);

    // Back-to-back with reserved mode, which behaves as pass.
    in_valid  = 1'b1;
    in_mode   = 2'd3;
    in_data   = VEC_B;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("b2b_busy_valid", VW'(out_valid), VW'(1'b0));
    repeat (3) step();
    check("b2b_busy_valid_3", VW'(out_valid), VW'(1'b0));
    step();
    check("rsvd_valid", VW'(out_valid), VW'(1'b1));
    check("rsvd_data", out_data, VEC_B);
`ifdef VEC_ACT_STATS_EN
    check("rsvd_neg", VW'(out_neg_count), VW'(4'd6));
`endif
    step();
    check("rsvd_drain", VW'(out_valid), VW'(1'b0));
    out_ready = 1'b0;

    // Reset while chunk 2 is pending, with in_valid also high.
    in_valid = 1'b1;
    in_mode  = 2'd1;
    in_data  = VEC_A;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    rst      = 1'b1;
    in_valid = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_mid_valid", VW'(out_valid), VW'(1'b0));
    check("rst_mid_in_ready", VW'(in_ready), VW'(1'b1));
    check("rst_mid_data", out_data, '0);
`ifdef VEC_ACT_STATS_EN
    check("rst_mid_neg", VW'(out_neg_count), VW'(4'd0));
`endif
    repeat (5) step();
    check("rst_no_partial", VW'(out_valid), VW'(1'b0));
    check("rst_idle_data", out_data, '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
